serial_deserializer: RTL and testbench

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

---
 rtl/serial_deserializer.sv | 135 +++++++++++++
 tb/tb_serial_deserializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with sof framing, a single-entry output
// register with ready/valid handshake, sticky overflow and one-cycle abort pulse.
module serial_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             abort
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             abort_q, abort_d;
    logic [WIDTH-1:0] first_s, append_s;
    logic             complete_s;

    // Bit placement: the first bit of a word drifts to MSB or LSB as later bits arrive.
    always_comb begin
        first_s  = {WIDTH{1'b0}};
        append_s = shreg_q;
        if (MSB_FIRST) begin
            first_s  = {{(WIDTH-1){1'b0}}, din};
            append_s = {shreg_q[WIDTH-2:0], din};
        end else begin
            first_s  = {din, {(WIDTH-1){1'b0}}};
            append_s = {din, shreg_q[WIDTH-1:1]};
        end
    end

    // Framing FSM plus output-register / flag next-state logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        abort_d     = 1'b0;
        complete_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid && sof) begin
                    shreg_d = first_s;
                    count_d = CW'(1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (din_valid && sof) begin
                    abort_d = 1'b1;
                    shreg_d = first_s;
                    count_d = CW'(1);
                end else if (din_valid) begin
                    shreg_d = append_s;
                    if (count_q == CW'(WIDTH - 1)) begin
                        complete_s = 1'b1;
                        count_d    = {CW{1'b0}};
                        state_d    = IDLE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {CW{1'b0}};
            end
        endcase

        // A completed word may replace a word being consumed in the same cycle.
        if (complete_s) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = append_s;
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= {CW{1'b0}};
            shreg_q     <= {WIDTH{1'b0}};
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            abort_q     <= abort_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: MSB-first and LSB-first instances share the
// same stimulus and are compared cycle by cycle against a queue-based model.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, ovf_m, ovf_l, abort_m, abort_l;

    int total = 0;
    int bad   = 0;

    // model state
    logic       bitq[$];
    logic       e_valid = 1'b0;
    logic [7:0] e_data_m = 8'h00;
    logic [7:0] e_data_l = 8'h00;
    logic       e_ovf = 1'b0;
    logic       e_abort = 1'b0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
        .overflow(ovf_m), .abort(abort_m)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
        .overflow(ovf_l), .abort(abort_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: collect the frame's bits in a queue, build the word arithmetically when 8 arrive.
    task automatic model_edge();
        logic       done;
        logic       ab;
        logic [7:0] wm, wl;
        done = 1'b0;
        ab   = 1'b0;
        wm   = 8'h00;
        wl   = 8'h00;
        if (rst) begin
            bitq.delete();
            e_valid  = 1'b0;
            e_data_m = 8'h00;
            e_data_l = 8'h00;
            e_ovf    = 1'b0;
            e_abort  = 1'b0;
        end else begin
            if (din_valid) begin
                if (sof) begin
                    if (bitq.size() != 0) ab = 1'b1;
                    bitq.delete();
                    bitq.push_back(din);
                end else if (bitq.size() != 0) begin
                    bitq.push_back(din);
                    if (bitq.size() == 8) begin
                        done = 1'b1;
                        for (int i = 0; i < 8; i++) begin
                            wm = wm * 8'd2 + {7'd0, bitq[i]};
                            wl = wl + ({7'd0, bitq[i]} << i);
                        end
                        bitq.delete();
                    end
                end
            end
            if (done) begin
                if (!e_valid || out_ready) begin
                    e_valid  = 1'b1;
                    e_data_m = wm;
                    e_data_l = wl;
                end else begin
                    e_ovf = 1'b1;
                end
            end else if (e_valid && out_ready) begin
                e_valid = 1'b0;
            end
            e_abort = ab;
        end
    endtask

    task automatic step(input logic dv, input logic s, input logic d);
        din_valid = dv;
        sof       = s;
        din       = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("valid_m", {31'd0, valid_m}, {31'd0, e_valid});
        chk("data_m",  {24'd0, data_m},  {24'd0, e_data_m});
        chk("ovf_m",   {31'd0, ovf_m},   {31'd0, e_ovf});
        chk("abort_m", {31'd0, abort_m}, {31'd0, e_abort});
        chk("valid_l", {31'd0, valid_l}, {31'd0, e_valid});
        chk("data_l",  {24'd0, data_l},  {24'd0, e_data_l});
        chk("ovf_l",   {31'd0, ovf_l},   {31'd0, e_ovf});
        chk("abort_l", {31'd0, abort_l}, {31'd0, e_abort});
    endtask

    // Send w MSB-first in time; up to maxgap idle (din_valid=0, junk sof/din) cycles before each bit.
    // last_rdy >= 0 forces out_ready for the cycle carrying the last bit.
    task automatic send_frame(input logic [7:0] w, input int maxgap, input int last_rdy);
        logic [7:0] wv;
        wv = w;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, maxgap)) step(1'b0, 1'($urandom), 1'($urandom));
            if (i == 7 && last_rdy >= 0) out_ready = 1'(last_rdy);
            step(1'b1, (i == 0), wv[7-i]);
        end
    endtask

    initial begin
        logic [7:0] w1, w2;

        // reset
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_valid", {31'd0, valid_m}, 32'd0);
        chk("rst_data",  {24'd0, data_m},  32'd0);
        rst = 1'b0;

        // basic frame, both bit orders, then a back-to-back frame
        out_ready = 1'b1;
        send_frame(8'hB2, 0, -1);
        chk("b2_msb", {24'd0, data_m}, 32'hB2);
        chk("b2_lsb", {24'd0, data_l}, 32'h4D);
        chk("b2_valid", {31'd0, valid_m}, 32'd1);
        send_frame(8'h3C, 0, -1);
        chk("b2b_msb", {24'd0, data_m}, 32'h3C);
        step(1'b0, 1'b0, 1'b0);
        chk("one_cycle_valid", {31'd0, valid_m}, 32'd0);

        // overflow with output held
        out_ready = 1'b0;
        send_frame(8'hB2, 0, -1);
        send_frame(8'h0F, 0, -1);
        chk("ovf_hold_data", {24'd0, data_m}, 32'hB2);
        chk("ovf_set", {31'd0, ovf_m}, 32'd1);
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_drain_valid", {31'd0, valid_m}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_m}, 32'd1);

        // abort on mid-frame sof
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'($urandom));
        step(1'b1, 1'b1, 1'b1);
        chk("abort_pulse", {31'd0, abort_m}, 32'd1);
        repeat (7) step(1'b1, 1'b0, 1'b1);
        chk("abort_ff", {24'd0, data_m}, 32'hFF);

        // reset mid-frame, then a clean frame
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'($urandom));
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        send_frame(8'hA5, 0, -1);
        chk("a5_data", {24'd0, data_m}, 32'hA5);
        chk("a5_ovf", {31'd0, ovf_m}, 32'd0);

        // gapped frames, ready only in the second completion cycle
        step(1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        send_frame(w1, 2, -1);
        chk("gap_w1", {24'd0, data_m}, {24'd0, w1});
        send_frame(w2, 2, 1);
        chk("gap_w2", {24'd0, data_m}, {24'd0, w2});
        chk("gap_valid", {31'd0, valid_m}, 32'd1);
        chk("gap_ovf", {31'd0, ovf_m}, 32'd0);

        // random soak
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            out_ready = 1'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 13) == 0), 1'($urandom));
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
